// File: rtl/bram_pkg.sv
// ============================================================================
// Module      : bram_pkg
// Description : Shared BRAM geometry, fill-FSM state encoding and LFSR
//               constants for the fill writer, read controller and checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bram_pkg;

    localparam int BRAM_ADDR_W = 4;
    localparam int BRAM_DATA_W = 8;
    localparam int BRAM_DEPTH  = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } fill_state_t;

    localparam logic [7:0] LFSR_TAPS      = 8'hB8;
    localparam logic [7:0] LFSR_ZERO_SEED = 8'h01;

endpackage

`default_nettype wire

// File: rtl/bram_pattern_gen.sv
// ============================================================================
// Module      : bram_pattern_gen
// Description : Fill-pattern sequencer. Additive (base + n) by default;
//               Galois LFSR (taps 8'hB8) when BRAM_FILL_LFSR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_pattern_gen
    import bram_pkg::*;
#(
    parameter int DATA_W = BRAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [DATA_W-1:0] base,
    output logic [DATA_W-1:0] value
);

    logic [DATA_W-1:0] r_cur;
    logic [DATA_W-1:0] w_seed;
    logic [DATA_W-1:0] w_step;
    logic [DATA_W-1:0] w_next;

`ifdef BRAM_FILL_LFSR_EN
    generate
        if (DATA_W != 8) begin : g_lfsr_width_check
            $error("bram_pattern_gen: LFSR pattern requires DATA_W == 8");
        end
    endgenerate

    // An all-zero LFSR state would lock up, so a zero base seeds with 8'h01.
    always_comb begin
        w_seed = (base == '0) ? DATA_W'(LFSR_ZERO_SEED) : base;
        w_step = {1'b0, r_cur[DATA_W-1:1]} ^ (r_cur[0] ? DATA_W'(LFSR_TAPS) : '0);
    end
`else
    always_comb begin
        w_seed = base;
        w_step = r_cur + DATA_W'(1);
    end
`endif

    always_comb begin
        w_next = r_cur;
        if (load) begin
            w_next = w_seed;
        end else if (advance) begin
            w_next = w_step;
        end
    end

    assign value = w_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur <= '0;
        end else begin
            r_cur <= w_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bram_fill_writer.sv
// ============================================================================
// Module      : bram_fill_writer
// Description : Fills every BRAM address with a deterministic pattern on
//               start; optional LFSR pattern via BRAM_FILL_LFSR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_fill_writer
    import bram_pkg::*;
#(
    parameter int ADDR_W = BRAM_ADDR_W,
    parameter int DATA_W = BRAM_DATA_W,
    parameter int DEPTH  = BRAM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              hold,
    input  logic [DATA_W-1:0] base,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);

    generate
        if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_depth_check
            $error("bram_fill_writer: DEPTH must be in 1..2**ADDR_W");
        end
    endgenerate

    fill_state_t       r_state;
    fill_state_t       w_state_nxt;
    logic              r_wea;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_dina;
    logic              r_busy;
    logic              r_done;
    logic              r_stalled;

    logic              w_wea_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_stalled_nxt;
    logic              w_load;
    logic              w_advance;
    logic              w_take_value;
    logic              w_clr_dina;
    logic [DATA_W-1:0] w_value;

    bram_pattern_gen #(
        .DATA_W (DATA_W)
    ) u_pattern (
        .clk     (clk),
        .rst     (reset),
        .load    (w_load),
        .advance (w_advance),
        .base    (base),
        .value   (w_value)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A held edge has already committed the word, so the cycle after the
    // stall re-presents it once (r_stalled) before the address moves on.
    always_comb begin
        w_state_nxt   = r_state;
        w_wea_nxt     = 1'b0;
        w_addr_nxt    = r_addr;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_stalled_nxt = r_stalled;
        w_load        = 1'b0;
        w_advance     = 1'b0;
        w_take_value  = 1'b0;
        w_clr_dina    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt   = WRITE;
                    w_load        = 1'b1;
                    w_take_value  = 1'b1;
                    w_wea_nxt     = 1'b1;
                    w_addr_nxt    = '0;
                    w_busy_nxt    = 1'b1;
                    w_stalled_nxt = 1'b0;
                end
            end
            WRITE: begin
                if (hold) begin
                    w_stalled_nxt = 1'b1;
                end else if (r_stalled) begin
                    w_wea_nxt     = 1'b1;
                    w_stalled_nxt = 1'b0;
                end else if (r_addr != c_LAST) begin
                    w_addr_nxt    = r_addr + ADDR_W'(1);
                    w_advance     = 1'b1;
                    w_take_value  = 1'b1;
                    w_wea_nxt     = 1'b1;
                end else begin
                    w_state_nxt   = IDLE;
                    w_addr_nxt    = '0;
                    w_clr_dina    = 1'b1;
                    w_busy_nxt    = 1'b0;
                    w_done_nxt    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wea     <= 1'b0;
            r_addr    <= '0;
            r_dina    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_stalled <= 1'b0;
        end else begin
            r_wea     <= w_wea_nxt;
            r_addr    <= w_addr_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_stalled <= w_stalled_nxt;
            if (w_take_value) begin
                r_dina <= w_value;
            end else if (w_clr_dina) begin
                r_dina <= '0;
            end
        end
    end

    assign wea   = r_wea;
    assign addra = r_addr;
    assign dina  = r_dina;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_bram_fill_writer.sv
// ============================================================================
// Module      : tb_bram_fill_writer
// Description : Self-checking bench for bram_fill_writer with a BRAM model
//               and a pattern reference computed from base and index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_fill_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       hold;
    logic [7:0] base;
    logic       wea;
    logic [3:0] addra;
    logic [7:0] dina;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [16];

    bram_fill_writer dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .hold  (hold),
        .base  (base),
        .wea   (wea),
        .addra (addra),
        .dina  (dina),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wea) mem[addra] <= dina;
    end

    typedef struct {
        logic [7:0] b;
        int         hold_at;
        int         hold_len;
        int         rep_at;
        logic [7:0] rep_b;
        int         exp_edges;
        int         exp_weas;
    } vec_t;

    vec_t vecs [5];

    // Word n of a fill started with base b.
    function automatic logic [7:0] pat(input logic [7:0] b, input int n);
        logic [7:0] v;
`ifdef BRAM_FILL_LFSR_EN
        v = (b == 8'h00) ? 8'h01 : b;
        for (int i = 0; i < n; i++) v = v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
`else
        v = 8'((int'(b) + n) % 256);
`endif
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs one fill from the current (IDLE) sample point and returns at the
    // sample where done is high. rnd selects random hold; then the edge and
    // write budgets are derived from the holds actually applied.
    task automatic run_fill(input logic [7:0] b, input int hold_at, input int hold_len,
                            input int rep_at, input logic [7:0] rep_b, input bit rnd,
                            input int exp_edges, input int exp_weas);
        int         edges, weas, held, hcnt, runs;
        bit         prev_hold, pulsed, seen;
        logic [3:0] hold_addr;
        edges = 0; weas = 0; held = 0; hcnt = 0; runs = 0;
        prev_hold = 0; pulsed = 0; seen = 0; hold_addr = 4'd0;
        start = 1'b1; base = b; hold = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; base = 8'($urandom);
        chk("first_wea",  wea,   1);
        chk("first_addr", addra, 0);
        chk("first_dina", dina,  pat(b, 0));
        chk("first_busy", busy,  1);
        chk("first_done", done,  0);
        while (edges < 400) begin
            if (done) begin seen = 1; break; end
            if (wea) begin
                weas++;
                chk("wdata", dina, pat(b, int'(addra)));
            end
            if (prev_hold) begin
                chk("hold_wea",  wea,   0);
                chk("hold_addr", addra, hold_addr);
            end
            start = 1'b0;
            if (rnd) hold = ($urandom_range(0, 3) == 0);
            else if (int'(addra) == hold_at && held < hold_len) begin hold = 1'b1; held++; end
            else hold = 1'b0;
            if (!pulsed && int'(addra) == rep_at) begin
                start = 1'b1; base = rep_b; pulsed = 1;
            end
            if (hold) begin hcnt++; hold_addr = addra; end
            else if (prev_hold) runs++;
            prev_hold = hold;
            @(posedge clk); #1;
            edges++;
        end
        start = 1'b0; hold = 1'b0;
        chk("done_seen", seen, 1);
        chk("fill_edges", edges, rnd ? 16 + hcnt + runs : exp_edges);
        chk("fill_weas",  weas,  rnd ? 16 + runs : exp_weas);
        chk("done_busy",  busy,  0);
        chk("done_wea",   wea,   0);
        chk("done_addr",  addra, 0);
        chk("done_dina",  dina,  0);
        for (int i = 0; i < 16; i++) chk("mem", mem[i], pat(b, i));
    endtask

    task automatic idle_step();
        @(posedge clk); #1;
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_wea",  wea,  0);
    endtask

    initial begin
        logic [7:0] lfsr_exp [8];
        int guard;
        vecs[0] = '{8'h10, -1, 0, -1, 8'h00, 16, 16};
        vecs[1] = '{8'hF8, -1, 0, -1, 8'h00, 16, 16};
        vecs[2] = '{8'h10,  5, 3, -1, 8'h00, 20, 17};
        vecs[3] = '{8'h33, -1, 0,  7, 8'h55, 16, 16};
        vecs[4] = '{8'hFF, 15, 1, -1, 8'h00, 18, 17};
        lfsr_exp = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3, 8'hE1, 8'hC8};

        reset = 1'b1; start = 1'b0; hold = 1'b0; base = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wea",  wea,   0);
        chk("rst_addr", addra, 0);
        chk("rst_dina", dina,  0);
        chk("rst_busy", busy,  0);
        chk("rst_done", done,  0);
        reset = 1'b0;
        idle_step();

        for (int v = 0; v < 5; v++) begin
            run_fill(vecs[v].b, vecs[v].hold_at, vecs[v].hold_len, vecs[v].rep_at,
                     vecs[v].rep_b, 1'b0, vecs[v].exp_edges, vecs[v].exp_weas);
            idle_step();
        end

        // Wrap case read back with literal values
        run_fill(8'hF8, -1, 0, -1, 8'h00, 1'b0, 16, 16);
`ifdef BRAM_FILL_LFSR_EN
        idle_step();
        run_fill(8'h00, -1, 0, -1, 8'h00, 1'b0, 16, 16);
        for (int i = 0; i < 8; i++) chk("lfsr_seq", mem[i], lfsr_exp[i]);
`else
        chk("wrap_mem7",  mem[7],  8'hFF);
        chk("wrap_mem8",  mem[8],  8'h00);
        chk("wrap_mem15", mem[15], 8'h07);
`endif

        // Back-to-back: start accepted in the done cycle
        run_fill(8'h40, -1, 0, -1, 8'h00, 1'b0, 16, 16);
        idle_step();

        // Asynchronous reset mid-fill
        start = 1'b1; base = 8'h22;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (addra != 4'd9 && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("reach_addr9", addra, 9);
        #2 reset = 1'b1;
        #1;
        chk("amid_wea",  wea,   0);
        chk("amid_addr", addra, 0);
        chk("amid_dina", dina,  0);
        chk("amid_busy", busy,  0);
        chk("amid_done", done,  0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle_step();
        run_fill(8'h22, -1, 0, -1, 8'h00, 1'b0, 16, 16);
        idle_step();

        // Random bases and hold patterns
        for (int r = 0; r < 8; r++) begin
            run_fill(8'($urandom), -1, 0, -1, 8'h00, 1'b1, 0, 0);
            if (($urandom_range(0, 1)) == 0) idle_step();
        end
        idle_step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
